// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// FSM encoding, lane/latency constants, address error check.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BE_W          = 4;
  localparam int DATA_W        = 32;
  localparam int DEF_READ_LAT  = 2;
  localparam int DEF_WRITE_LAT = 1;

  // Full-width compare so out-of-range addresses never alias
  // onto a valid word.
  function automatic logic addr_err(
    input logic [63:0] addr,
    input int unsigned depth
  );
    return (addr[1:0] != 2'b00) ||
           ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Load/store memory request/response bus (valid/ready both ways).
// master = pipeline MEM stage, slave = memory responder.
interface mem_resp_if #(
  parameter int ADDR_W = 32
) ();

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [ADDR_W-1:0]                req_addr;
  logic [mem_resp_pkg::DATA_W-1:0]  req_wdata;
  logic [mem_resp_pkg::BE_W-1:0]    req_be;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [mem_resp_pkg::DATA_W-1:0]  resp_rdata;
  logic                             resp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word storage, byte-enabled write, registered
// read-before-write. Ports: clk, en, we, be, idx, wdata, rdata.
module mem_word_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset; only the responder FSM is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[idx];
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with programmable latency.
// Ports: clk, rst (sync, active-high), bus (slave), busy.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = DEF_READ_LAT,
  parameter int WRITE_LAT   = DEF_WRITE_LAT
) (
  input  logic      clk,
  input  logic      rst,
  mem_resp_if.slave bus,
  output logic      busy
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int MAX_LAT =
    (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  state_t state_q, state_d;

  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q,    be_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              cur_err;
  logic              lat_one;
  logic [CNT_W-1:0]  lat_m1;

  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;

  // In IDLE the live request drives the array so a 1-cycle
  // access commits on its accept edge; later, the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_wr    = bus.req_write;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
      cur_err   = addr_err(64'(bus.req_addr), DEPTH_WORDS);
    end else begin
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      cur_err   = err_q;
    end
    lat_one = cur_wr ? (WRITE_LAT == 1) : (READ_LAT == 1);
    lat_m1  = cur_wr ? CNT_W'(WRITE_LAT - 1)
                     : CNT_W'(READ_LAT - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          err_d   = cur_err;
          if (cur_err || lat_one) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_m1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Commit strobe: one array access on the edge entering RESP.
  // Reset wins, so a dropped request never touches storage.
  always_comb begin
    arr_en = !rst && !cur_err &&
             (state_q != RESP) && (state_d == RESP);
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (cur_wr),
    .be    (cur_be),
    .idx   (cur_addr[IDX_W+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // Array read data only changes on a commit, so it holds
  // stable for the whole RESP stall.
  always_comb begin
    busy           = (state_q != IDLE);
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = '0;
    if ((state_q == RESP) && !wr_q && !err_q) begin
      bus.resp_rdata = arr_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// Vector table + scoreboard, plus stall/reset/back-to-back runs.
module tb_data_mem_responder;

  localparam int RL_A = 2;
  localparam int WL_A = 1;
  localparam int LAT_B = 4;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic busy_a;
  logic busy_b;

  int checks = 0;
  int errors = 0;

  mem_resp_if #(.ADDR_W(32)) bus_a ();
  mem_resp_if #(.ADDR_W(32)) bus_b ();

  data_mem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (1024),
    .READ_LAT    (RL_A),
    .WRITE_LAT   (WL_A)
  ) dut_a (
    .clk  (clk),
    .rst  (rst_a),
    .bus  (bus_a),
    .busy (busy_a)
  );

  data_mem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (64),
    .READ_LAT    (LAT_B),
    .WRITE_LAT   (LAT_B)
  ) dut_b (
    .clk  (clk),
    .rst  (rst_b),
    .bus  (bus_b),
    .busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare on every response handshake of dut_a.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus_a.resp_valid && bus_a.resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_rdata", bus_a.resp_rdata, e.rd);
        chk("sb_err", 32'(bus_a.resp_err), 32'(e.err));
      end
    end
  end

  task automatic xact_a(input vec_t v, input string tag);
    int n;
    int lat;
    lat = v.err ? 1 : (v.wr ? WL_A : RL_A);
    bus_a.req_valid  = 1'b1;
    bus_a.req_write  = v.wr;
    bus_a.req_addr   = v.addr;
    bus_a.req_wdata  = v.wd;
    bus_a.req_be     = v.be;
    bus_a.resp_ready = 1'b1;
    sb_q.push_back('{rd: v.rd, err: v.err});
    n = 0;
    while (!bus_a.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_accept_timeout"}, 32'(n), 32'(0));
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    n = 1;
    while (!bus_a.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    @(negedge clk);
  endtask

  task automatic xact_b(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] exp_rd,
                        input string tag);
    int n;
    bus_b.req_valid  = 1'b1;
    bus_b.req_write  = wr;
    bus_b.req_addr   = addr;
    bus_b.req_wdata  = wd;
    bus_b.req_be     = 4'hF;
    bus_b.resp_ready = 1'b1;
    n = 0;
    while (!bus_b.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_accept_timeout"}, 32'(n), 32'(0));
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    n = 1;
    while (!bus_b.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT_B));
    chk({tag, "_rdata"}, bus_b.resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(bus_b.resp_err), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int t;
    int busyc;
    int acc_t[3];
    int n;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF,
                 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,
                 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0, 4'h0,
                 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF,
                 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101,
                 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0, 4'h0,
                 32'h11BB_33DD, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0, 4'h0,
                 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0, 4'h0,
                 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF,
                 32'h0, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0022, 32'h9999_9999, 4'hF,
                 32'h0, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0,
                 32'h0102_0304, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0,
                 32'h11BB_33DD, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF,
                 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0, 4'h0,
                 32'hCAFE_F00D, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'hF,
                 32'h0, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0030, 32'h1234_5678, 4'b1000,
                 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0030, 32'h0, 4'h0,
                 32'h12FF_FFFF, 1'b0};
    vecs[17] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0,
                 32'h0, 1'b1};

    bus_a.req_valid  = 1'b0;
    bus_a.req_write  = 1'b0;
    bus_a.req_addr   = '0;
    bus_a.req_wdata  = '0;
    bus_a.req_be     = '0;
    bus_a.resp_ready = 1'b0;
    bus_b.req_valid  = 1'b0;
    bus_b.req_write  = 1'b0;
    bus_b.req_addr   = '0;
    bus_b.req_wdata  = '0;
    bus_b.req_be     = '0;
    bus_b.resp_ready = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    chk("rst_req_ready", 32'(bus_a.req_ready), 32'(1));
    chk("rst_resp_valid", 32'(bus_a.resp_valid), 32'(0));
    chk("rst_rdata", bus_a.resp_rdata, 32'h0);
    chk("rst_err", 32'(bus_a.resp_err), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));

    for (int i = 0; i < 18; i++) begin
      xact_a(vecs[i], $sformatf("vec%0d", i));
    end

    // Response stall with a second request waiting.
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid  = 1'b1;
    bus_a.req_write  = 1'b0;
    bus_a.req_addr   = 32'h10;
    sb_q.push_back('{rd: 32'hDEAD_BEEF, err: 1'b0});
    @(negedge clk);
    bus_a.req_addr = 32'h20;
    sb_q.push_back('{rd: 32'h11BB_33DD, err: 1'b0});
    chk("stall_wait_ready", 32'(bus_a.req_ready), 32'(0));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus_a.resp_valid), 32'(1));
      chk("stall_rdata", bus_a.resp_rdata, 32'hDEAD_BEEF);
      chk("stall_err", 32'(bus_a.resp_err), 32'(0));
      chk("stall_req_ready", 32'(bus_a.req_ready), 32'(0));
      chk("stall_busy", 32'(busy_a), 32'(1));
      @(negedge clk);
    end
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_req_ready", 32'(bus_a.req_ready), 32'(1));
    chk("post_hs_valid", 32'(bus_a.resp_valid), 32'(0));
    chk("post_hs_rdata", bus_a.resp_rdata, 32'h0);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    n = 1;
    while (!bus_a.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_second_latency", 32'(n), 32'(RL_A));
    @(negedge clk);

    // Back-to-back loads, req_valid held high.
    bus_a.req_valid  = 1'b1;
    bus_a.req_write  = 1'b0;
    bus_a.req_addr   = 32'h10;
    bus_a.resp_ready = 1'b1;
    acc = 0;
    t = 0;
    busyc = 0;
    while (acc < 3 && t < 40) begin
      if (bus_a.req_ready) begin
        sb_q.push_back('{rd: 32'hDEAD_BEEF, err: 1'b0});
        if (acc > 0) begin
          chk("b2b_busy_cycles", 32'(busyc), 32'(RL_A));
        end
        acc_t[acc] = t;
        busyc = 0;
        acc++;
      end else if (busy_a) begin
        busyc++;
      end
      @(negedge clk);
      t++;
    end
    bus_a.req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'(3));
    chk("b2b_space0", 32'(acc_t[1] - acc_t[0]), 32'(RL_A + 1));
    chk("b2b_space1", 32'(acc_t[2] - acc_t[1]), 32'(RL_A + 1));
    n = 0;
    while (busy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);

    // Reset during WAIT of a store drops it.
    xact_b(1'b1, 32'h40, 32'h5A5A_1234, 32'h0, "b_store_old");
    bus_b.req_valid = 1'b1;
    bus_b.req_write = 1'b1;
    bus_b.req_addr  = 32'h40;
    bus_b.req_wdata = 32'hFFFF_0000;
    bus_b.req_be    = 4'hF;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    @(negedge clk);
    chk("b_wait_busy", 32'(busy_b), 32'(1));
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_rst_req_ready", 32'(bus_b.req_ready), 32'(1));
    chk("b_rst_resp_valid", 32'(bus_b.resp_valid), 32'(0));
    chk("b_rst_rdata", bus_b.resp_rdata, 32'h0);
    chk("b_rst_err", 32'(bus_b.resp_err), 32'(0));
    chk("b_rst_busy", 32'(busy_b), 32'(0));
    repeat (6) @(negedge clk);
    xact_b(1'b0, 32'h40, 32'h0, 32'h5A5A_1234, "b_load_old");

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
